// File: rtl/pulse_gen_pkg.sv
// Shared types for the multi-channel pulse generator: channel FSM states and mode encodings.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_t;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse generator channel: programmable period/high-time, continuous or one-shot,
// with shadow registers so new settings only take effect at a period boundary.
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] high_i,
  output logic             y_o,
  output logic             tick_o,
  output logic             busy_o
);

  ch_state_t        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pAct_q, pAct_d;
  logic [WIDTH-1:0] hAct_q, hAct_d;
  logic [WIDTH-1:0] lastCnt;
  logic             periodValid;

  assign lastCnt     = pAct_q - WIDTH'(1);
  assign periodValid = (period_i != '0);

  // Next-state logic; disable always wins over the period-end decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pAct_d  = pAct_q;
    hAct_d  = hAct_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_i && periodValid) begin
          pAct_d  = period_i;
          hAct_d  = high_i;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == lastCnt) begin
          cnt_d = '0;
          if (mode_i == MODE_ONESHOT) begin
            state_d = DONE;
          end else if (periodValid) begin
            pAct_d = period_i;
            hAct_d = high_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      DONE: begin
        cnt_d = '0;
        if (!en_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pAct_q  <= '0;
      hAct_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pAct_q  <= pAct_d;
      hAct_q  <= hAct_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign y_o    = busy_o && (cnt_q < hAct_q);
  assign tick_o = busy_o && (cnt_q == '0);

endmodule

// File: rtl/pulse_gen_multi.sv
// N_CH independent pulse generator channels sharing only clock and reset;
// period/high buses are flattened with channel i at bits [i*WIDTH +: WIDTH].
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH*WIDTH-1:0] period,
  input  logic [N_CH*WIDTH-1:0] high,
  output logic [N_CH-1:0]       y_pulse,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       busy
);

  for (genvar g = 0; g < N_CH; g++) begin : gen_ch
    pulse_gen_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .en_i    (en[g]),
      .mode_i  (mode[g]),
      .period_i(period[g*WIDTH +: WIDTH]),
      .high_i  (high[g*WIDTH +: WIDTH]),
      .y_o     (y_pulse[g]),
      .tick_o  (tick[g]),
      .busy_o  (busy[g])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Self-checking bench for pulse_gen_multi: expected per-cycle outputs are queued as stimulus
// is driven and compared after each rising edge.
module tb_pulse_gen_multi;
  import pulse_gen_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 32;

  logic               clk;
  logic               rstn;
  logic [NCH-1:0]     en;
  logic [NCH-1:0]     mode;
  logic [NCH*W-1:0]   period;
  logic [NCH*W-1:0]   high;
  logic [NCH-1:0]     y_pulse;
  logic [NCH-1:0]     tick;
  logic [NCH-1:0]     busy;

  typedef struct {
    logic [NCH-1:0] y;
    logic [NCH-1:0] t;
    logic [NCH-1:0] b;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   errorCount = 0;
  int   pCfg[NCH];
  int   hCfg[NCH];

  pulse_gen_multi #(
    .N_CH (NCH),
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .mode   (mode),
    .period (period),
    .high   (high),
    .y_pulse(y_pulse),
    .tick   (tick),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setCh(input int ch, input int p, input int h);
    period[ch*W +: W] = p;
    high[ch*W +: W]   = h;
    pCfg[ch] = p;
    hCfg[ch] = h;
  endtask

  // Ideal waveform k cycles into a continuous run for the channels in act.
  function automatic exp_t runExp(input int k, input logic [NCH-1:0] act);
    exp_t e;
    e.y = '0;
    e.t = '0;
    e.b = '0;
    for (int i = 0; i < NCH; i++) begin
      if (act[i]) begin
        e.y[i] = ((k % pCfg[i]) < hCfg[i]);
        e.t[i] = ((k % pCfg[i]) == 0);
        e.b[i] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic quiesce();
    en   = '0;
    mode = '0;
    for (int i = 0; i < NCH; i++) setCh(i, 0, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t z;
    z.y = '0;
    z.t = '0;
    z.b = '0;
    for (int i = 0; i < NCH; i++) setCh(i, 4, 2);
    en   = 4'hF;
    mode = '0;
    for (int k = 0; k < 11; k++) begin
      rstn = (k >= 3);
      expQ.push_back((k < 3) ? z : runExp(k - 3, 4'hF));
      @(posedge clk);
      @(negedge clk);
      e = expQ.pop_front();
      checkCount++;
      if ({y_pulse, tick, busy} !== {e.y, e.t, e.b}) begin
        errorCount++;
        $display("[TB] FAIL reset k=%0d: y/tick/busy actual %b/%b/%b required %b/%b/%b",
                 k, y_pulse, tick, busy, e.y, e.t, e.b);
      end
    end
  endtask

  task automatic test_continuous();
    exp_t e;
    quiesce();
    setCh(0, 4, 2);
    setCh(1, 5, 2);
    setCh(2, 5, 0);
    setCh(3, 5, 7);
    en = 4'hF;
    for (int k = 0; k < 20; k++) begin
      expQ.push_back(runExp(k, 4'hF));
      @(posedge clk);
      @(negedge clk);
      e = expQ.pop_front();
      checkCount++;
      if ({y_pulse, tick, busy} !== {e.y, e.t, e.b}) begin
        errorCount++;
        $display("[TB] FAIL continuous k=%0d: y/tick/busy actual %b/%b/%b required %b/%b/%b",
                 k, y_pulse, tick, busy, e.y, e.t, e.b);
      end
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    int   j;
    quiesce();
    setCh(0, 3, 1);
    mode = {3'b000, MODE_ONESHOT};
    en   = 4'b0001;
    for (int k = 0; k < 13; k++) begin
      en[0] = (k != 6);
      j = (k < 6) ? k : k - 7;
      e.y = '0;
      e.t = '0;
      e.b = '0;
      if (k != 6) begin
        e.y[0] = (j == 0);
        e.t[0] = (j == 0);
        e.b[0] = (j < 3);
      end
      expQ.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = expQ.pop_front();
      checkCount++;
      if ({y_pulse, tick, busy} !== {e.y, e.t, e.b}) begin
        errorCount++;
        $display("[TB] FAIL oneshot k=%0d: y/tick/busy actual %b/%b/%b required %b/%b/%b",
                 k, y_pulse, tick, busy, e.y, e.t, e.b);
      end
    end
  endtask

  task automatic test_reload();
    exp_t        e;
    logic [10:0] yPat;
    logic [10:0] tPat;
    yPat = 11'b10001110011;
    tPat = 11'b10000010001;
    quiesce();
    setCh(0, 4, 2);
    en = 4'b0001;
    for (int k = 0; k < 11; k++) begin
      if (k == 2) setCh(0, 6, 3);
      e.y = {3'b000, yPat[k]};
      e.t = {3'b000, tPat[k]};
      e.b = 4'b0001;
      expQ.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = expQ.pop_front();
      checkCount++;
      if ({y_pulse, tick, busy} !== {e.y, e.t, e.b}) begin
        errorCount++;
        $display("[TB] FAIL reload k=%0d: y/tick/busy actual %b/%b/%b required %b/%b/%b",
                 k, y_pulse, tick, busy, e.y, e.t, e.b);
      end
    end
  endtask

  task automatic test_disable();
    exp_t e;
    quiesce();
    setCh(0, 4, 2);
    setCh(1, 5, 2);
    en = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) en[0] = 1'b0;
      expQ.push_back(runExp(k, (k < 2) ? 4'b0011 : 4'b0010));
      @(posedge clk);
      @(negedge clk);
      e = expQ.pop_front();
      checkCount++;
      if ({y_pulse, tick, busy} !== {e.y, e.t, e.b}) begin
        errorCount++;
        $display("[TB] FAIL disable k=%0d: y/tick/busy actual %b/%b/%b required %b/%b/%b",
                 k, y_pulse, tick, busy, e.y, e.t, e.b);
      end
    end
  endtask

  task automatic test_degenerate();
    exp_t e;
    quiesce();
    setCh(0, 1, 1);
    setCh(1, 0, 3);
    en = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      expQ.push_back(runExp(k, 4'b0001));
      @(posedge clk);
      @(negedge clk);
      e = expQ.pop_front();
      checkCount++;
      if ({y_pulse, tick, busy} !== {e.y, e.t, e.b}) begin
        errorCount++;
        $display("[TB] FAIL degenerate k=%0d: y/tick/busy actual %b/%b/%b required %b/%b/%b",
                 k, y_pulse, tick, busy, e.y, e.t, e.b);
      end
    end
  endtask

  initial begin
    rstn   = 1'b0;
    en     = '0;
    mode   = '0;
    period = '0;
    high   = '0;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_oneshot();
    test_reload();
    test_disable();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
